// File: rtl/mac_loader_pkg.sv
// Shared mac package: lane count, mac pipeline latency, byte and sum widths,
// plus the loader FSM state type. The mac datapath imports the same package,
// so loader and mac always agree on vector layout and latency.
package mac_loader_pkg;

  localparam int MAC_LANES   = 16;
  localparam int MAC_LATENCY = 3;
  localparam int BYTE_W      = 8;
  localparam int SUM_W       = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/mac_loader_if.sv
// Handshake bundle for mac_loader.
//   in_valid/in_ready/in_pixel/in_weight : byte-pair input stream
//   res_valid/res_ready/res_data         : frame dot-product result stream
// master: the producer/consumer side (parent or bench)
// slave : the loader itself
interface mac_loader_if;
  import mac_loader_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [BYTE_W-1:0] in_pixel;
  logic [BYTE_W-1:0] in_weight;
  logic              res_valid;
  logic              res_ready;
  logic [SUM_W-1:0]  res_data;

  modport master (
    output in_valid, in_pixel, in_weight, res_ready,
    input  in_ready, res_valid, res_data
  );

  modport slave (
    input  in_valid, in_pixel, in_weight, res_ready,
    output in_ready, res_valid, res_data
  );

endinterface

// File: rtl/mac_loader.sv
// mac_loader: gathers LANES pixel/weight byte pairs into the packed vectors
// feeding the mac datapath, waits out the mac latency, then captures the mac
// sum and offers it downstream.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus (slave)         : in_* pair stream and res_* result stream
//   pixels_o, weights_o : packed vectors to mac, first pair in the MSB lane
//   mac_sum_i           : mac sum output
//   busy                : high whenever a frame or result is in flight
module mac_loader
  import mac_loader_pkg::*;
#(
  parameter int LANES   = mac_loader_pkg::MAC_LANES,
  parameter int MAC_LAT = mac_loader_pkg::MAC_LATENCY
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mac_loader_if.slave             bus,
  output logic [LANES*BYTE_W-1:0] pixels_o,
  output logic [LANES*BYTE_W-1:0] weights_o,
  input  logic [SUM_W-1:0]        mac_sum_i,
  output logic                    busy
);

  localparam int CNT_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int WCNT_W = $clog2(MAC_LAT + 2);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    lane_cnt;
  logic [WCNT_W-1:0]   wait_cnt;
  logic                res_valid_q;
  logic [SUM_W-1:0]    res_data_q;
  logic                xfer;
  logic                last_pair;
  logic                wait_done;
  logic                res_take;

  // in_ready is also gated by rst_n so nothing is accepted while reset is held.
  assign bus.in_ready  = rst_n && (state_q == IDLE || state_q == LOAD);
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign busy          = (state_q != IDLE);

  assign xfer      = bus.in_valid && bus.in_ready;
  assign last_pair = xfer && (lane_cnt == CNT_W'(LANES - 1));
  assign wait_done = (state_q == WAIT) && (wait_cnt == WCNT_W'(MAC_LAT));
  assign res_take  = res_valid_q && bus.res_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (xfer)      state_d = last_pair ? WAIT : LOAD;
      LOAD: if (last_pair) state_d = WAIT;
      WAIT: if (wait_done) state_d = OUT;
      OUT:  if (res_take)  state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Load stage: pair k lands in lane LANES-1-k; the vectors stay frozen from
  // the last accept until the next frame starts, since in_ready is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_cnt  <= '0;
      pixels_o  <= '0;
      weights_o <= '0;
    end else if (xfer) begin
      lane_cnt <= last_pair ? '0 : lane_cnt + 1'b1;
      pixels_o[(LANES - 1 - int'(lane_cnt)) * BYTE_W +: BYTE_W]  <= bus.in_pixel;
      weights_o[(LANES - 1 - int'(lane_cnt)) * BYTE_W +: BYTE_W] <= bus.in_weight;
    end
  end

  // Wait/capture stage: MAC_LAT+1 cycles in WAIT covers the edge on which mac
  // samples the new vectors plus its MAC_LAT pipeline edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      if (state_q == WAIT) wait_cnt <= wait_done ? '0 : wait_cnt + 1'b1;
      if (wait_done) begin
        res_data_q  <= mac_sum_i;
        res_valid_q <= 1'b1;
      end else if (res_take) begin
        res_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mac_loader.md
MAC_LOADER -- requirements
Module: mac_loader

Interface
REQ-001 SHALL have parameter LANES, 16, number of pixel/weight lanes per frame.
REQ-002 SHALL have parameter MAC_LAT, 3, clock edges from the mac vector inputs being sampled to a valid mac sum.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  pixel/weight byte pair offered.
REQ-006 SHALL have port in_ready  output  1  loader accepts a pair this cycle.
REQ-007 SHALL have port in_pixel  input  8  unsigned pixel byte.
REQ-008 SHALL have port in_weight  input  8  unsigned weight byte.
REQ-009 SHALL have port pixels_o  output  128  packed pixel vector driving mac pixelsIn.
REQ-010 SHALL have port weights_o  output  128  packed weight vector driving mac weightsIn.
REQ-011 SHALL have port mac_sum_i  input  20  mac sumOut.
REQ-012 SHALL have port res_valid  output  1  frame dot-product result available.
REQ-013 SHALL have port res_ready  input  1  downstream takes result.
REQ-014 SHALL have port res_data  output  20  captured unsigned dot product.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, WAIT, OUT; IDLE->LOAD on first accepted pair, LOAD->WAIT on accepting pair LANES, WAIT->OUT after the wait count, OUT->IDLE on res handshake.
REQ-017 SHALL assert in_ready only in IDLE and LOAD; a pair transfers when in_valid && in_ready at a rising edge.
REQ-018 SHALL write accepted pair k (k=0..15 within the frame) to pixels_o/weights_o bits [127-8k : 120-8k], first pair in the MSB lane.
REQ-019 SHALL keep a 4-bit lane counter, incremented per transfer, cleared on entry to WAIT; in_valid gaps stall without loss or reordering.
REQ-020 SHALL hold pixels_o/weights_o constant from the edge accepting pair 15 until the state returns to IDLE.
REQ-021 SHALL remain in WAIT for exactly MAC_LAT+1 cycles, then capture mac_sum_i into res_data on the edge leaving WAIT, with res_valid high from that edge.
REQ-022 SHALL hold res_data and res_valid stable in OUT while res_ready is low; on res_valid && res_ready, return to IDLE and drop res_valid on that edge.
REQ-023 SHALL NOT accept input pairs in WAIT or OUT (in_ready=0), including when res_ready is high in the same cycle.
REQ-024 SHALL treat all data as unsigned; the maximum result 16*255*255=1040400 fits 20 bits without overflow handling.
REQ-025 SHALL ignore in_pixel/in_weight when no transfer occurs.

Reset
REQ-026 SHALL, on rst_n low, asynchronously force state IDLE, lane counter 0, wait counter 0, pixels_o=0, weights_o=0, res_data=0, res_valid=0, busy=0, in_ready=0 while reset is asserted.
REQ-027 SHALL, when reset occurs mid-LOAD, WAIT or OUT, discard the partial frame or result; the first pair after release is lane 0.

Structure
REQ-028 SHALL take LANES, MAC_LAT, byte width 8 and sum width 20 from the shared mac package, which the mac datapath also uses.
REQ-029 SHALL contain no sub-module; the parent instantiates mac_loader next to mac and connects the vectors and sum directly.

Verification
REQ-030 SHALL test 16 pairs (1,1), no gaps, res_ready=1 -> res_data=16, res_valid rises MAC_LAT+1 cycles after the final accept.
REQ-031 SHALL test 16 pairs (255,255) -> res_data=1040400; pixels_o=weights_o=all ones during WAIT.
REQ-032 SHALL test pixel=k, weight=1 for k=0..15 with random in_valid gaps -> res_data=120; pixels_o[127:120]=0 and [7:0]=15.
REQ-033 SHALL test res_ready low for 10 cycles after res_valid -> res_data held, in_ready=0 throughout, IDLE one edge after handshake.
REQ-034 SHALL test rst_n pulsed low after 7 pairs, then a full frame of (2,3) -> res_data=96, no residue from the aborted frame.
REQ-035 SHALL test back-to-back frames (1,1) then (2,2) with res_ready=1 -> results 16 then 64, in order, neither dropped.
